// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures a slow or divided clock (sig_in) against the system clock
//   (clk_in). Reports the rise-to-rise period and the rise-to-fall high
//   time in clk_in cycles, pulses meas_valid once per completed period,
//   and flags frequency lock and loss of signal.
//
// Parameters
//   CNT_WIDTH  : width of the cycle counter and of period/high_time
//   LOCK_COUNT : consecutive matching periods needed for locked (1..15)
//   TOLERANCE  : largest |new - previous| period still counted as a match
//
// Ports
//   clk_in     in   system clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   measurement enable, low forces IDLE
//   sig_in     in   clock under test, asynchronous to clk_in
//   period     out  last measured period (saturates at 2^CNT_WIDTH-1)
//   high_time  out  last measured high time
//   meas_valid out  one-cycle pulse when period/high_time update
//   locked     out  period stable for LOCK_COUNT consecutive measurements
//   timeout    out  no rising edge seen within 2^CNT_WIDTH-1 cycles
//
// Handshake: meas_valid is a strobe with no ready; period, high_time and
// locked are valid in the cycle meas_valid is high and hold afterwards.
module clk_period_meter #(
  parameter int CNT_WIDTH  = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOLERANCE  = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] TOL     = CNT_WIDTH'(TOLERANCE);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

  // ---------------------------------------------------------------------
  // Input path: 2-flop synchronizer, then one edge register.
  // ---------------------------------------------------------------------
  logic       sync1;
  logic       s_sync;
  logic       s_d;
  // The synchronizer holds its reset zeros for two edges after reset
  // release, which would make a sig_in already high look like a low
  // followed by a rise. settle[1] marks s_sync as trustworthy.
  logic [1:0] settle;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      s_sync <= 1'b0;
      s_d    <= 1'b0;
      settle <= 2'b00;
    end else begin
      sync1  <= sig_in;
      s_sync <= sync1;
      s_d    <= s_sync;
      settle <= {settle[0], 1'b1};
    end
  end

  logic rise;
  logic fall;
  assign rise = s_sync & ~s_d;
  assign fall = ~s_sync & s_d;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] hi_cap;
  logic [CNT_WIDTH-1:0] hi_cap_nxt;
  logic [3:0]           match_cnt;
  logic [3:0]           match_nxt;
  logic [CNT_WIDTH-1:0] period_nxt;
  logic [CNT_WIDTH-1:0] high_time_nxt;
  logic                 meas_valid_nxt;
  logic                 locked_nxt;
  logic                 timeout_nxt;

  // cnt+1 carries one extra bit so that a rise coinciding with counter
  // saturation yields 2^CNT_WIDTH, which is then clamped to CNT_MAX.
  logic [CNT_WIDTH:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] new_period;
  logic [CNT_WIDTH-1:0] period_diff;
  logic                 period_match;
  logic [3:0]           match_upd;

  assign cnt_inc     = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign new_period  = cnt_inc[CNT_WIDTH] ? CNT_MAX : cnt_inc[CNT_WIDTH-1:0];
  // The period register still holds the previous measurement here.
  assign period_diff = (new_period >= period) ? (new_period - period)
                                              : (period - new_period);
  assign period_match = (period_diff <= TOL);

  // Match count after the measurement completing this cycle. A zero
  // count means this is the first measurement since ARM.
  always_comb begin
    match_upd = 4'd1;
    if (match_cnt != 4'd0 && period_match) begin
      if (match_cnt >= LOCK_N) begin
        match_upd = LOCK_N;
      end else begin
        match_upd = match_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      match_cnt  <= 4'd0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hi_cap     <= hi_cap_nxt;
      match_cnt  <= match_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= meas_valid_nxt;
      locked     <= locked_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and next-value logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hi_cap_nxt     = hi_cap;
    match_nxt      = match_cnt;
    period_nxt     = period;
    high_time_nxt  = high_time;
    meas_valid_nxt = 1'b0;
    locked_nxt     = locked;
    timeout_nxt    = timeout;

    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        locked_nxt = 1'b0;
        match_nxt  = 4'd0;
        // Arm only on a known-low input so a level already high is never
        // mistaken for a rising edge.
        if (en && settle[1] && !s_sync) begin
          state_nxt = ARM;
        end
      end

      ARM: begin
        cnt_nxt = '0;
        if (!en) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
          match_nxt  = 4'd0;
        end else if (rise) begin
          state_nxt = MEASURE;
        end
      end

      MEASURE: begin
        if (!en) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          locked_nxt = 1'b0;
          match_nxt  = 4'd0;
        end else if (rise) begin
          // A rise wins over counter saturation in the same cycle.
          period_nxt     = new_period;
          high_time_nxt  = hi_cap;
          meas_valid_nxt = 1'b1;
          cnt_nxt        = '0;
          timeout_nxt    = 1'b0;
          match_nxt      = match_upd;
          locked_nxt     = (match_upd == LOCK_N);
        end else if (cnt == CNT_MAX) begin
          state_nxt   = TIMEOUT;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          match_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_inc[CNT_WIDTH-1:0];
          if (fall) begin
            hi_cap_nxt = new_period;
          end
        end
      end

      TIMEOUT: begin
        cnt_nxt = '0;
        // timeout stays set here and through IDLE until a measurement
        // completes or reset.
        if (!en) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
          match_nxt  = 4'd0;
        end else if (!s_sync) begin
          state_nxt = ARM;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Directed bench for clk_period_meter (CNT_WIDTH=8, LOCK_COUNT=4,
//   TOLERANCE=1). A background generator shapes sig_in as hi_len cycles
//   high and lo_len cycles low (optionally alternating lo_len/lo_len+1);
//   the main block walks a linear sequence of steps with hand-computed
//   expectations sampled on the falling clock edge.
module tb_clk_period_meter;

  localparam int W = 8;

  logic         clk_in;
  logic         rst_n;
  logic         en;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  // Generator controls
  logic gen_on   = 1'b0;
  logic idle_lvl = 1'b0;
  logic alt_on   = 1'b0;
  logic alt_bit  = 1'b0;
  int   hi_len   = 2;
  int   lo_len   = 2;
  int   lo_cur   = 2;

  clk_period_meter #(
    .CNT_WIDTH  (W),
    .LOCK_COUNT (4),
    .TOLERANCE  (1)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  // ---------------- clock / reset ----------------
  // Posedges at 10,20,...; negedges at 5,15,... so reset release at 15 ns
  // falls away from the active edge.
  initial begin
    clk_in = 1'b1;
    forever #5 clk_in = ~clk_in;
  end

  // ---------------- sig_in generator ----------------
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk_in);
      if (gen_on) begin
        #2 sig_in = 1'b1;
        repeat (hi_len) @(posedge clk_in);
        #2 sig_in = 1'b0;
        lo_cur = lo_len + ((alt_on && alt_bit) ? 1 : 0);
        alt_bit = ~alt_bit;
        repeat (lo_cur - 1) @(posedge clk_in);
      end else begin
        #2 sig_in = idle_lvl;
        alt_bit = 1'b0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the next meas_valid sample; returns negedges waited.
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk_in);
      if (meas_valid === 1'b1) begin
        cycles = i;
        return;
      end
    end
    total++;
    bad++;
    $error("FAIL %s: observed=no meas_valid expected=meas_valid within 600 cycles", tag);
  endtask

  task automatic count_valids(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk_in);
      if (meas_valid === 1'b1) seen++;
    end
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int seen;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;

    // Reset state
    @(negedge clk_in);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);

    // Divide-by-4 (2 high / 2 low), reset released at 15 ns
    @(negedge clk_in);
    rst_n  = 1'b1;
    hi_len = 2;
    lo_len = 2;
    gen_on = 1'b1;

    wait_valid("d4_v1", cyc);
    check("d4_v1_period", period, 4);
    check("d4_v1_high", high_time, 2);
    check("d4_v1_locked", locked, 0);
    check("d4_v1_timeout", timeout, 0);
    @(negedge clk_in);
    check("d4_pulse_width", meas_valid, 0);
    wait_valid("d4_v2", cyc);
    check("d4_v2_gap", cyc, 3);  // one negedge already consumed above
    check("d4_v2_locked", locked, 0);
    wait_valid("d4_v3", cyc);
    check("d4_v3_gap", cyc, 4);
    check("d4_v3_locked", locked, 0);
    wait_valid("d4_v4", cyc);
    check("d4_v4_gap", cyc, 4);
    check("d4_v4_period", period, 4);
    check("d4_v4_locked", locked, 1);

    // Switch to divide-by-6. The pulse already in flight is still 2/2.
    hi_len = 3;
    lo_len = 3;
    wait_valid("d6_v0", cyc);
    check("d6_v0_period", period, 4);
    check("d6_v0_locked", locked, 1);
    wait_valid("d6_v1", cyc);
    check("d6_v1_gap", cyc, 6);
    check("d6_v1_period", period, 6);
    check("d6_v1_high", high_time, 3);
    check("d6_v1_locked", locked, 0);
    wait_valid("d6_v2", cyc);
    check("d6_v2_locked", locked, 0);
    wait_valid("d6_v3", cyc);
    check("d6_v3_gap", cyc, 6);
    check("d6_v3_locked", locked, 0);
    wait_valid("d6_v4", cyc);
    check("d6_v4_period", period, 6);
    check("d6_v4_locked", locked, 1);

    // Drop en: IDLE clears locked, period is retained
    en     = 1'b0;
    gen_on = 1'b0;
    @(negedge clk_in);
    check("en_off_locked", locked, 0);
    check("en_off_period", period, 6);
    repeat (10) @(negedge clk_in);

    // Tolerance 1: periods 4,5,4,5,4,5 then 7
    alt_on = 1'b1;
    hi_len = 2;
    lo_len = 2;
    en     = 1'b1;
    gen_on = 1'b1;
    wait_valid("tol_v1", cyc);
    check("tol_v1_period", period, 4);
    check("tol_v1_locked", locked, 0);
    wait_valid("tol_v2", cyc);
    check("tol_v2_gap", cyc, 5);
    check("tol_v2_period", period, 5);
    check("tol_v2_locked", locked, 0);
    wait_valid("tol_v3", cyc);
    check("tol_v3_gap", cyc, 4);
    check("tol_v3_period", period, 4);
    check("tol_v3_locked", locked, 0);
    wait_valid("tol_v4", cyc);
    check("tol_v4_period", period, 5);
    check("tol_v4_locked", locked, 1);
    wait_valid("tol_v5", cyc);
    check("tol_v5_period", period, 4);
    check("tol_v5_locked", locked, 1);
    alt_on = 1'b0;
    lo_len = 5;
    wait_valid("tol_v6", cyc);
    check("tol_v6_period", period, 5);
    check("tol_v6_locked", locked, 1);
    wait_valid("tol_v7", cyc);
    check("tol_v7_period", period, 7);
    check("tol_v7_high", high_time, 2);
    check("tol_v7_locked", locked, 0);

    // Timeout: lock at 4, then stop sig_in low
    en     = 1'b0;
    gen_on = 1'b0;
    lo_len = 2;
    repeat (10) @(negedge clk_in);
    en     = 1'b1;
    gen_on = 1'b1;
    wait_valid("to_v1", cyc);
    wait_valid("to_v2", cyc);
    wait_valid("to_v3", cyc);
    wait_valid("to_v4", cyc);
    check("to_lock_locked", locked, 1);
    check("to_lock_period", period, 4);
    gen_on = 1'b0;
    // The rise reported here was the last one; cnt runs 0..255 on the
    // following edges and the edge after cnt=255 enters TIMEOUT.
    repeat (255) @(negedge clk_in);
    check("to_pre_timeout", timeout, 0);
    check("to_pre_locked", locked, 1);
    @(negedge clk_in);
    check("to_timeout", timeout, 1);
    check("to_locked", locked, 0);
    check("to_period_hold", period, 4);
    check("to_high_hold", high_time, 2);

    // Restart: first rise only arms, second rise completes a measurement
    repeat (4) @(negedge clk_in);
    gen_on = 1'b1;
    repeat (5) @(negedge clk_in);
    check("rs_timeout_held", timeout, 1);
    wait_valid("rs_v1", cyc);
    check("rs_v1_gap", cyc, 3);
    check("rs_v1_timeout", timeout, 0);
    check("rs_v1_period", period, 4);
    check("rs_v1_high", high_time, 2);
    check("rs_v1_locked", locked, 0);
    wait_valid("rs_v2", cyc);
    wait_valid("rs_v3", cyc);
    wait_valid("rs_v4", cyc);
    check("rs_v4_locked", locked, 1);

    // Asynchronous reset mid-measurement
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_period", period, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_valid", meas_valid, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_timeout", timeout, 0);

    // sig_in held high through reset release
    gen_on   = 1'b0;
    idle_lvl = 1'b1;
    repeat (5) @(negedge clk_in);
    rst_n = 1'b1;
    count_valids(10, seen);
    check("hi_rel_no_valid", seen, 0);
    check("hi_rel_locked", locked, 0);
    gen_on = 1'b1;
    // Edges after gen_on: fall at 3, first real rise detected at 8,
    // second at 12.
    wait_valid("hi_rel_v1", cyc);
    check("hi_rel_v1_gap", cyc, 12);
    check("hi_rel_v1_period", period, 4);
    check("hi_rel_v1_high", high_time, 2);
    wait_valid("hi_rel_v2", cyc);
    wait_valid("hi_rel_v3", cyc);
    wait_valid("hi_rel_v4", cyc);
    check("hi_rel_v4_locked", locked, 1);

    // en dropped mid-measurement
    en = 1'b0;
    @(negedge clk_in);
    check("en_mid_locked", locked, 0);
    check("en_mid_valid", meas_valid, 0);
    count_valids(12, seen);
    check("en_mid_no_valid", seen, 0);
    check("en_mid_period", period, 4);
    check("en_mid_high", high_time, 2);
    check("en_mid_timeout", timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
